exu_alu_pipe: RTL and testbench
===============================

Name: exu_alu_pipe

Overview:
- Parametrised, pipelined integer ALU execution unit for the out-of-order core.
- Sits between the ALU reservation station and the PRF/ROB writeback port.
- Accepts one uop per cycle with a valid/ready handshake and produces results after LATENCY cycles.
- Supports writeback back-pressure, per-entry ROB-age flush kill and exception pass-through.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be 32 or 64.
- ROB_ID_WIDTH, 8, ROB id width; the MSB is the wrap bit.
- PRF_CODE_WIDTH, 7, physical register code width.
- EXCP_WIDTH, 5, exception code width; 0 means no exception.
- LATENCY, 2, pipeline stages from issue to writeback; legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_trap_flush  in  1  kill all in-flight entries
- i_mis_flush  in  1  branch mispredict flush
- i_mis_rob_id  in  ROB_ID_WIDTH  mispredict flush ROB id
- i_ls_flush  in  1  load/store replay flush
- i_ls_rob_id  in  ROB_ID_WIDTH  load/store flush ROB id
- i_iss_vld  in  1  issue valid
- o_iss_rdy  out  1  issue ready
- i_iss_op  in  4  opcode: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI (pass op2); 11-15 reserved, result 0
- i_iss_src1_vld  in  1  1: op1 = src1; 0: op1 = pc
- i_iss_src1  in  DATA_WIDTH  source 1 data
- i_iss_opimm  in  1  1: op2 = imm; 0: op2 = src2
- i_iss_src2  in  DATA_WIDTH  source 2 data
- i_iss_imm  in  DATA_WIDTH  sign-extended immediate
- i_iss_pc  in  DATA_WIDTH  instruction address
- i_iss_dst_vld  in  1  writes a destination register
- i_iss_dst_code  in  PRF_CODE_WIDTH  destination PRF code
- i_iss_rob_id  in  ROB_ID_WIDTH  ROB id
- i_iss_excp  in  EXCP_WIDTH  exception code from upstream
- o_wb_vld  out  1  writeback valid
- i_wb_rdy  in  1  writeback ready
- o_wb_dst_vld  out  1  PRF write enable qualifier
- o_wb_dst_code  out  PRF_CODE_WIDTH  destination PRF code
- o_wb_dat  out  DATA_WIDTH  result data
- o_wb_rob_id  out  ROB_ID_WIDTH  ROB id
- o_wb_excp  out  EXCP_WIDTH  exception code
- o_occupancy  out  3  number of valid pipeline stages, 0..LATENCY

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All stage valid bits clear on reset. At reset: o_wb_vld=0, o_occupancy=0, o_iss_rdy=1, data outputs=0.
- Datapath: the result is computed combinationally at issue and carried through LATENCY register stages S0..S(L-1). S(L-1) drives the wb outputs.
- Arithmetic: add/sub wrap modulo 2^DATA_WIDTH. Shift amount is op2[4:0] for DATA_WIDTH=32 and op2[5:0] for 64. SLT is signed, SLTU unsigned; the result is zero-extended 0/1.
- Exceptions: if i_iss_excp!=0, the data is forced to 0 and dst_vld to 0, and the excp code is carried to o_wb_excp.
- Stage advance: stage k advances when it is valid and (stage k+1 is empty or advancing). S(L-1) advances on o_wb_vld & i_wb_rdy.
- Issue: o_iss_rdy = S0 empty or S0 advancing. An issue fires on i_iss_vld & o_iss_rdy.
- Bubbles collapse, so back-to-back issue sustains 1 op/cycle. With no stall, an op issued at cycle t has o_wb_vld at t+LATENCY.
- Writeback back-pressure: while o_wb_vld=1 and i_wb_rdy=0, all wb outputs hold stable. Upstream stages fill until full, then o_iss_rdy=0.
- ROB age: A is older than B iff
  - MSBs differ: A[low] >= B[low];
  - MSBs equal: A[low] < B[low].
- Effective flush id: if both i_mis_flush and i_ls_flush are asserted, use the older of the two ids; otherwise use whichever is asserted.
- Kill rule: an entry is killed when i_trap_flush=1, or when an effective flush is active and the flush id is older than the entry's ROB id. An entry equal to the flush id survives.
- Kill timing: a killed entry's valid clears at the next edge. o_wb_vld is masked combinationally in the flush cycle: o_wb_vld = S(L-1).vld & ~kill. An issuing op that matches the kill rule in the same cycle is accepted (handshake completes) but is not written into S0.
- Flush with stall: when a flush and a stall coincide, surviving entries hold their place and killed entries become bubbles. Occupancy drops accordingly.
- o_occupancy equals the count of valid stages after kill, as registered state.

Test Plan:
- Throughput: LATENCY=2, issue ADD 5+7 at cycle 0 and SUB 3-5 at cycle 1, i_wb_rdy=1 -> o_wb_dat=12 at cycle 2 and 0xFFFFFFFE at cycle 3; o_iss_rdy stays 1 throughout.
- Operations and exception pass-through:
  - SRA 0x80000000>>4 -> 0xF8000000.
  - SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
  - src1_vld=0, pc=0x100, imm=8, ADD -> 0x108.
  - excp=2 -> dat=0, dst_vld=0, o_wb_excp=2.
- Back-pressure: hold i_wb_rdy=0 with 3 issues at LATENCY=2 -> pipeline fills, o_iss_rdy=0 once both stages are valid, the third op stalls, outputs stay stable; release -> ops drain in order, one per cycle.
- Flush by age: in-flight ROB ids 0x05, 0x06, 0x07; i_mis_flush with id 0x06 -> 0x07 killed, 0x05 and 0x06 written back. Wrap case: flush id 0x7F with entry 0x81 -> entry killed.
- Dual flush and trap: mis id 0x10 and ls id 0x0C asserted together -> 0x0C used, entry 0x0E killed. i_trap_flush while the output is stalled -> o_wb_vld=0 the same cycle, occupancy 0 at the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously with 2 entries in flight -> o_wb_vld=0 and o_occupancy=0 immediately; after release, the first issue completes at the nominal latency.

Source files
------------

// File: rtl/exu_alu_pipe.sv
// Pipelined integer ALU execution unit: computes at issue, carries the result through
// LATENCY stages to writeback, with back-pressure, ROB-age flush kill and exception pass-through.
module exu_alu_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROB_ID_WIDTH   = 8,
  parameter int PRF_CODE_WIDTH = 7,
  parameter int EXCP_WIDTH     = 5,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_trap_flush,
  input  logic                      i_mis_flush,
  input  logic [ROB_ID_WIDTH-1:0]   i_mis_rob_id,
  input  logic                      i_ls_flush,
  input  logic [ROB_ID_WIDTH-1:0]   i_ls_rob_id,
  input  logic                      i_iss_vld,
  output logic                      o_iss_rdy,
  input  logic [3:0]                i_iss_op,
  input  logic                      i_iss_src1_vld,
  input  logic [DATA_WIDTH-1:0]     i_iss_src1,
  input  logic                      i_iss_opimm,
  input  logic [DATA_WIDTH-1:0]     i_iss_src2,
  input  logic [DATA_WIDTH-1:0]     i_iss_imm,
  input  logic [DATA_WIDTH-1:0]     i_iss_pc,
  input  logic                      i_iss_dst_vld,
  input  logic [PRF_CODE_WIDTH-1:0] i_iss_dst_code,
  input  logic [ROB_ID_WIDTH-1:0]   i_iss_rob_id,
  input  logic [EXCP_WIDTH-1:0]     i_iss_excp,
  output logic                      o_wb_vld,
  input  logic                      i_wb_rdy,
  output logic                      o_wb_dst_vld,
  output logic [PRF_CODE_WIDTH-1:0] o_wb_dst_code,
  output logic [DATA_WIDTH-1:0]     o_wb_dat,
  output logic [ROB_ID_WIDTH-1:0]   o_wb_rob_id,
  output logic [EXCP_WIDTH-1:0]     o_wb_excp,
  output logic [2:0]                o_occupancy
);

  localparam int SHW = (DATA_WIDTH == 64) ? 6 : 5;
  localparam int RL  = ROB_ID_WIDTH - 1;

  // ROB ids wrap; the MSB tells whether the two ids sit in the same lap.
  function automatic logic is_older(input logic [ROB_ID_WIDTH-1:0] a,
                                    input logic [ROB_ID_WIDTH-1:0] b);
    if (a[RL] != b[RL]) return (a[RL-1:0] >= b[RL-1:0]);
    return (a[RL-1:0] < b[RL-1:0]);
  endfunction

  logic [DATA_WIDTH-1:0]     op1, op2, alu_res, iss_dat;
  logic [SHW-1:0]            shamt;
  logic                      iss_dst_vld;
  logic                      iss_fire;
  logic                      kill_iss;
  logic                      flush_act;
  logic [ROB_ID_WIDTH-1:0]   flush_id;
  logic                      adv_chain;
  logic [2:0]                occ_nxt;

  logic [LATENCY-1:0]        s_vld, kill, adv, load, in_vld, vld_nxt;
  logic                      s_dst_vld  [LATENCY];
  logic [PRF_CODE_WIDTH-1:0] s_dst_code [LATENCY];
  logic [DATA_WIDTH-1:0]     s_dat      [LATENCY];
  logic [ROB_ID_WIDTH-1:0]   s_rob      [LATENCY];
  logic [EXCP_WIDTH-1:0]     s_excp     [LATENCY];

  always_comb begin
    op1   = i_iss_src1_vld ? i_iss_src1 : i_iss_pc;
    op2   = i_iss_opimm ? i_iss_imm : i_iss_src2;
    shamt = op2[SHW-1:0];
    case (i_iss_op)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'd3:    alu_res = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = op1 << shamt;
      4'd6:    alu_res = op1 >> shamt;
      4'd7:    alu_res = $signed(op1) >>> shamt;
      4'd8:    alu_res = op1 | op2;
      4'd9:    alu_res = op1 & op2;
      4'd10:   alu_res = op2;
      default: alu_res = '0;
    endcase
    iss_dat     = (i_iss_excp != '0) ? '0 : alu_res;
    iss_dst_vld = i_iss_dst_vld & (i_iss_excp == '0);
  end

  // With both flushes pending, the older id covers the larger set of victims.
  always_comb begin
    flush_act = i_mis_flush | i_ls_flush;
    if (i_mis_flush && i_ls_flush)
      flush_id = is_older(i_mis_rob_id, i_ls_rob_id) ? i_mis_rob_id : i_ls_rob_id;
    else if (i_mis_flush)
      flush_id = i_mis_rob_id;
    else
      flush_id = i_ls_rob_id;
    kill_iss = i_trap_flush | (flush_act & is_older(flush_id, i_iss_rob_id));
    kill = '0;
    for (int k = 0; k < LATENCY; k++)
      kill[k] = i_trap_flush | (flush_act & is_older(flush_id, s_rob[k]));
  end

  always_comb begin
    adv_chain        = s_vld[LATENCY-1] & ~kill[LATENCY-1] & i_wb_rdy;
    adv              = '0;
    adv[LATENCY-1]   = adv_chain;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      adv_chain = s_vld[k] & (~s_vld[k+1] | adv_chain);
      adv[k]    = adv_chain;
    end
  end

  assign o_iss_rdy = ~s_vld[0] | adv[0];
  assign iss_fire  = i_iss_vld & o_iss_rdy;

  // Killed entries become bubbles in place; stalled survivors keep their stage.
  always_comb begin
    load      = '0;
    in_vld    = '0;
    vld_nxt   = '0;
    occ_nxt   = '0;
    load[0]   = iss_fire;
    in_vld[0] = iss_fire & ~kill_iss;
    for (int k = 1; k < LATENCY; k++) begin
      load[k]   = adv[k-1];
      in_vld[k] = adv[k-1] & ~kill[k-1];
    end
    for (int k = 0; k < LATENCY; k++) begin
      if (load[k])
        vld_nxt[k] = in_vld[k];
      else if (adv[k])
        vld_nxt[k] = 1'b0;
      else
        vld_nxt[k] = s_vld[k] & ~kill[k];
      occ_nxt = occ_nxt + {2'b00, vld_nxt[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld       <= '0;
      o_occupancy <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        s_dst_vld[k]  <= 1'b0;
        s_dst_code[k] <= '0;
        s_dat[k]      <= '0;
        s_rob[k]      <= '0;
        s_excp[k]     <= '0;
      end
    end else begin
      s_vld       <= vld_nxt;
      o_occupancy <= occ_nxt;
      if (in_vld[0]) begin
        s_dst_vld[0]  <= iss_dst_vld;
        s_dst_code[0] <= i_iss_dst_code;
        s_dat[0]      <= iss_dat;
        s_rob[0]      <= i_iss_rob_id;
        s_excp[0]     <= i_iss_excp;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (in_vld[k]) begin
          s_dst_vld[k]  <= s_dst_vld[k-1];
          s_dst_code[k] <= s_dst_code[k-1];
          s_dat[k]      <= s_dat[k-1];
          s_rob[k]      <= s_rob[k-1];
          s_excp[k]     <= s_excp[k-1];
        end
      end
    end
  end

  assign o_wb_vld      = s_vld[LATENCY-1] & ~kill[LATENCY-1];
  assign o_wb_dst_vld  = s_dst_vld[LATENCY-1];
  assign o_wb_dst_code = s_dst_code[LATENCY-1];
  assign o_wb_dat      = s_dat[LATENCY-1];
  assign o_wb_rob_id   = s_rob[LATENCY-1];
  assign o_wb_excp     = s_excp[LATENCY-1];

endmodule

// File: tb/tb_exu_alu_pipe.sv
// Directed bench for exu_alu_pipe at default parameters (32-bit data, LATENCY=2):
// a vector table for the ALU ops plus hand sequences for stall, flush, trap and reset.
module tb_exu_alu_pipe;

  typedef struct {
    logic [3:0]  op;
    logic        s1v;
    logic [31:0] s1;
    logic        opimm;
    logic [31:0] s2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  excp;
    logic [31:0] exp_dat;
    logic        exp_dst_vld;
  } vec_t;

  logic        clk, rst_n;
  logic        i_trap_flush, i_mis_flush, i_ls_flush;
  logic [7:0]  i_mis_rob_id, i_ls_rob_id;
  logic        i_iss_vld, o_iss_rdy;
  logic [3:0]  i_iss_op;
  logic        i_iss_src1_vld, i_iss_opimm, i_iss_dst_vld;
  logic [31:0] i_iss_src1, i_iss_src2, i_iss_imm, i_iss_pc;
  logic [6:0]  i_iss_dst_code;
  logic [7:0]  i_iss_rob_id;
  logic [4:0]  i_iss_excp;
  logic        o_wb_vld, i_wb_rdy, o_wb_dst_vld;
  logic [6:0]  o_wb_dst_code;
  logic [31:0] o_wb_dat;
  logic [7:0]  o_wb_rob_id;
  logic [4:0]  o_wb_excp;
  logic [2:0]  o_occupancy;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t vecs[16];

  exu_alu_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .i_trap_flush(i_trap_flush),
    .i_mis_flush(i_mis_flush), .i_mis_rob_id(i_mis_rob_id),
    .i_ls_flush(i_ls_flush), .i_ls_rob_id(i_ls_rob_id),
    .i_iss_vld(i_iss_vld), .o_iss_rdy(o_iss_rdy),
    .i_iss_op(i_iss_op),
    .i_iss_src1_vld(i_iss_src1_vld), .i_iss_src1(i_iss_src1),
    .i_iss_opimm(i_iss_opimm), .i_iss_src2(i_iss_src2),
    .i_iss_imm(i_iss_imm), .i_iss_pc(i_iss_pc),
    .i_iss_dst_vld(i_iss_dst_vld), .i_iss_dst_code(i_iss_dst_code),
    .i_iss_rob_id(i_iss_rob_id), .i_iss_excp(i_iss_excp),
    .o_wb_vld(o_wb_vld), .i_wb_rdy(i_wb_rdy),
    .o_wb_dst_vld(o_wb_dst_vld), .o_wb_dst_code(o_wb_dst_code),
    .o_wb_dat(o_wb_dat), .o_wb_rob_id(o_wb_rob_id),
    .o_wb_excp(o_wb_excp), .o_occupancy(o_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] op, input logic s1v, input logic [31:0] s1,
                              input logic opimm, input logic [31:0] s2, input logic [31:0] imm,
                              input logic [31:0] pc, input logic [4:0] excp,
                              input logic [31:0] exp_dat, input logic exp_dst_vld);
    vec_t v;
    v.op = op; v.s1v = s1v; v.s1 = s1; v.opimm = opimm; v.s2 = s2; v.imm = imm;
    v.pc = pc; v.excp = excp; v.exp_dat = exp_dat; v.exp_dst_vld = exp_dst_vld;
    return v;
  endfunction

  function automatic vec_t rr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_dat);
    return mk(op, 1'b1, a, 1'b0, b, 32'h0, 32'h0, 5'd0, exp_dat, 1'b1);
  endfunction

  task automatic applyStimulus(input vec_t v, input logic [7:0] rob);
    i_iss_vld      = 1'b1;
    i_iss_op       = v.op;
    i_iss_src1_vld = v.s1v;
    i_iss_src1     = v.s1;
    i_iss_opimm    = v.opimm;
    i_iss_src2     = v.s2;
    i_iss_imm      = v.imm;
    i_iss_pc       = v.pc;
    i_iss_excp     = v.excp;
    i_iss_dst_vld  = 1'b1;
    i_iss_rob_id   = rob;
    i_iss_dst_code = rob[6:0] + 7'd1;
  endtask

  task automatic idle();
    i_iss_vld = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    i_trap_flush = 1'b0; i_mis_flush = 1'b0; i_ls_flush = 1'b0;
    i_mis_rob_id = '0; i_ls_rob_id = '0;
    i_wb_rdy = 1'b1;
    applyStimulus(rr(4'd0, 32'd0, 32'd0, 32'd0), 8'h00);
    idle();

    vecs[0]  = rr(4'd0,  32'd5,        32'd7,        32'd12);
    vecs[1]  = rr(4'd1,  32'd3,        32'd5,        32'hFFFF_FFFE);
    vecs[2]  = rr(4'd7,  32'h8000_0000, 32'd4,       32'hF800_0000);
    vecs[3]  = rr(4'd2,  32'hFFFF_FFFF, 32'd1,       32'd1);
    vecs[4]  = rr(4'd3,  32'hFFFF_FFFF, 32'd1,       32'd0);
    vecs[5]  = mk(4'd0, 1'b0, 32'hDEAD, 1'b1, 32'h55, 32'd8, 32'h100, 5'd0, 32'h108, 1'b1);
    vecs[6]  = mk(4'd0, 1'b1, 32'd1, 1'b0, 32'd1, 32'd0, 32'd0, 5'd2, 32'd0, 1'b0);
    vecs[7]  = rr(4'd5,  32'd1,        32'h3F,       32'h8000_0000);
    vecs[8]  = rr(4'd6,  32'h8000_0000, 32'd31,      32'd1);
    vecs[9]  = rr(4'd4,  32'hF0F0,     32'hFF00,     32'h0FF0);
    vecs[10] = rr(4'd8,  32'hF0,       32'h0F,       32'hFF);
    vecs[11] = rr(4'd9,  32'hF0,       32'h3C,       32'h30);
    vecs[12] = mk(4'd10, 1'b1, 32'h77, 1'b1, 32'h99, 32'h1234_5000, 32'd0, 5'd0, 32'h1234_5000, 1'b1);
    vecs[13] = rr(4'd12, 32'h1234,     32'h5678,     32'd0);
    vecs[14] = rr(4'd0,  32'hFFFF_FFFF, 32'd1,       32'd0);
    vecs[15] = rr(4'd3,  32'd1,        32'hFFFF_FFFF, 32'd1);

    #1;
    checkOutput("reset_wb_vld", 64'(o_wb_vld), 64'd0);
    checkOutput("reset_occ", 64'(o_occupancy), 64'd0);
    checkOutput("reset_iss_rdy", 64'(o_iss_rdy), 64'd1);
    checkOutput("reset_dat", 64'(o_wb_dat), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back throughput
    @(negedge clk); applyStimulus(vecs[0], 8'h01); #1;
    checkOutput("tp_rdy0", 64'(o_iss_rdy), 64'd1);
    @(negedge clk); applyStimulus(vecs[1], 8'h02); #1;
    checkOutput("tp_rdy1", 64'(o_iss_rdy), 64'd1);
    checkOutput("tp_vld_early", 64'(o_wb_vld), 64'd0);
    @(negedge clk); idle(); #1;
    checkOutput("tp_rdy2", 64'(o_iss_rdy), 64'd1);
    checkOutput("tp_vld_a", 64'(o_wb_vld), 64'd1);
    checkOutput("tp_dat_a", 64'(o_wb_dat), 64'd12);
    @(negedge clk); #1;
    checkOutput("tp_vld_b", 64'(o_wb_vld), 64'd1);
    checkOutput("tp_dat_b", 64'(o_wb_dat), 64'hFFFF_FFFE);
    @(negedge clk); #1;
    checkOutput("tp_drain_vld", 64'(o_wb_vld), 64'd0);
    checkOutput("tp_drain_occ", 64'(o_occupancy), 64'd0);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); applyStimulus(vecs[i], 8'(8'h10 + i));
      @(negedge clk); idle();
      @(negedge clk); #1;
      checkOutput($sformatf("vec%0d_vld", i), 64'(o_wb_vld), 64'd1);
      checkOutput($sformatf("vec%0d_dat", i), 64'(o_wb_dat), 64'(vecs[i].exp_dat));
      checkOutput($sformatf("vec%0d_dst_vld", i), 64'(o_wb_dst_vld), 64'(vecs[i].exp_dst_vld));
      checkOutput($sformatf("vec%0d_excp", i), 64'(o_wb_excp), 64'(vecs[i].excp));
      checkOutput($sformatf("vec%0d_rob", i), 64'(o_wb_rob_id), 64'(8'h10 + i));
      checkOutput($sformatf("vec%0d_code", i), 64'(o_wb_dst_code), 64'(7'(8'h10 + i) + 7'd1));
    end
    @(negedge clk);

    // Back-pressure: fill, stall the third op, then drain in order
    @(negedge clk); i_wb_rdy = 1'b0; applyStimulus(rr(4'd0, 32'd1, 32'd0, 32'd1), 8'h21); #1;
    checkOutput("bp_rdy_a", 64'(o_iss_rdy), 64'd1);
    @(negedge clk); applyStimulus(rr(4'd0, 32'd2, 32'd0, 32'd2), 8'h22); #1;
    checkOutput("bp_rdy_b", 64'(o_iss_rdy), 64'd1);
    @(negedge clk); applyStimulus(rr(4'd0, 32'd3, 32'd0, 32'd3), 8'h23); #1;
    checkOutput("bp_rdy_full", 64'(o_iss_rdy), 64'd0);
    checkOutput("bp_occ_full", 64'(o_occupancy), 64'd2);
    checkOutput("bp_vld", 64'(o_wb_vld), 64'd1);
    checkOutput("bp_dat", 64'(o_wb_dat), 64'd1);
    @(negedge clk); #1;
    checkOutput("bp_dat_hold", 64'(o_wb_dat), 64'd1);
    checkOutput("bp_rob_hold", 64'(o_wb_rob_id), 64'h21);
    checkOutput("bp_rdy_hold", 64'(o_iss_rdy), 64'd0);
    i_wb_rdy = 1'b1; #1;
    checkOutput("bp_rdy_release", 64'(o_iss_rdy), 64'd1);
    @(negedge clk); idle(); #1;
    checkOutput("bp_drain2", 64'(o_wb_dat), 64'd2);
    checkOutput("bp_drain2_occ", 64'(o_occupancy), 64'd2);
    @(negedge clk); #1;
    checkOutput("bp_drain3", 64'(o_wb_dat), 64'd3);
    checkOutput("bp_drain3_occ", 64'(o_occupancy), 64'd1);
    @(negedge clk); #1;
    checkOutput("bp_empty", 64'(o_wb_vld), 64'd0);

    // Flush by age: issuing 0x07 is accepted but dropped, 0x05/0x06 survive
    @(negedge clk); applyStimulus(rr(4'd0, 32'd5, 32'd0, 32'd5), 8'h05);
    @(negedge clk); applyStimulus(rr(4'd0, 32'd6, 32'd0, 32'd6), 8'h06);
    @(negedge clk); applyStimulus(rr(4'd0, 32'd7, 32'd0, 32'd7), 8'h07);
    i_mis_flush = 1'b1; i_mis_rob_id = 8'h06; #1;
    checkOutput("age_rdy", 64'(o_iss_rdy), 64'd1);
    checkOutput("age_wb5_vld", 64'(o_wb_vld), 64'd1);
    checkOutput("age_wb5_rob", 64'(o_wb_rob_id), 64'h05);
    @(negedge clk); i_mis_flush = 1'b0; idle(); #1;
    checkOutput("age_wb6_vld", 64'(o_wb_vld), 64'd1);
    checkOutput("age_wb6_rob", 64'(o_wb_rob_id), 64'h06);
    checkOutput("age_occ", 64'(o_occupancy), 64'd1);
    @(negedge clk); #1;
    checkOutput("age_7_killed", 64'(o_wb_vld), 64'd0);
    checkOutput("age_occ0", 64'(o_occupancy), 64'd0);

    // Wrap-around age: flush 0x7F kills 0x81 at the output in the same cycle
    @(negedge clk); applyStimulus(rr(4'd0, 32'd9, 32'd0, 32'd9), 8'h81);
    @(negedge clk); idle();
    @(negedge clk); #1;
    checkOutput("wrap_pre_vld", 64'(o_wb_vld), 64'd1);
    i_mis_flush = 1'b1; i_mis_rob_id = 8'h7F; #1;
    checkOutput("wrap_masked", 64'(o_wb_vld), 64'd0);
    @(negedge clk); i_mis_flush = 1'b0; #1;
    checkOutput("wrap_occ", 64'(o_occupancy), 64'd0);
    checkOutput("wrap_vld", 64'(o_wb_vld), 64'd0);

    // Mispredict 0x10 alone spares the older entry 0x0E
    @(negedge clk); applyStimulus(rr(4'd0, 32'd14, 32'd0, 32'd14), 8'h0E);
    @(negedge clk); idle(); i_mis_flush = 1'b1; i_mis_rob_id = 8'h10;
    @(negedge clk); i_mis_flush = 1'b0; #1;
    checkOutput("mis_only_survive", 64'(o_wb_vld), 64'd1);
    checkOutput("mis_only_rob", 64'(o_wb_rob_id), 64'h0E);

    // Dual flush: the older ls id 0x0C wins and kills 0x0E
    @(negedge clk); applyStimulus(rr(4'd0, 32'd14, 32'd0, 32'd14), 8'h0E);
    @(negedge clk); idle();
    i_mis_flush = 1'b1; i_mis_rob_id = 8'h10; i_ls_flush = 1'b1; i_ls_rob_id = 8'h0C;
    @(negedge clk); i_mis_flush = 1'b0; i_ls_flush = 1'b0; #1;
    checkOutput("dual_occ", 64'(o_occupancy), 64'd0);
    checkOutput("dual_vld", 64'(o_wb_vld), 64'd0);

    // Trap while the writeback port is stalled
    @(negedge clk); i_wb_rdy = 1'b0; applyStimulus(rr(4'd0, 32'd1, 32'd1, 32'd2), 8'h30);
    @(negedge clk); applyStimulus(rr(4'd0, 32'd2, 32'd1, 32'd3), 8'h31);
    @(negedge clk); idle(); #1;
    checkOutput("trap_pre_occ", 64'(o_occupancy), 64'd2);
    checkOutput("trap_pre_vld", 64'(o_wb_vld), 64'd1);
    i_trap_flush = 1'b1; #1;
    checkOutput("trap_masked", 64'(o_wb_vld), 64'd0);
    @(negedge clk); i_trap_flush = 1'b0; #1;
    checkOutput("trap_occ", 64'(o_occupancy), 64'd0);
    checkOutput("trap_vld", 64'(o_wb_vld), 64'd0);
    checkOutput("trap_rdy", 64'(o_iss_rdy), 64'd1);
    i_wb_rdy = 1'b1;

    // Asynchronous reset with two entries in flight
    @(negedge clk); applyStimulus(rr(4'd0, 32'd4, 32'd4, 32'd8), 8'h40);
    @(negedge clk); applyStimulus(rr(4'd0, 32'd5, 32'd5, 32'd10), 8'h41);
    @(negedge clk); idle(); #1;
    checkOutput("rst_pre_occ", 64'(o_occupancy), 64'd2);
    rst_n = 1'b0; #1;
    checkOutput("rst_async_vld", 64'(o_wb_vld), 64'd0);
    checkOutput("rst_async_occ", 64'(o_occupancy), 64'd0);
    checkOutput("rst_async_dat", 64'(o_wb_dat), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); applyStimulus(rr(4'd0, 32'd9, 32'd1, 32'd10), 8'h42);
    @(negedge clk); idle(); #1;
    checkOutput("rst_post_early", 64'(o_wb_vld), 64'd0);
    @(negedge clk); #1;
    checkOutput("rst_post_vld", 64'(o_wb_vld), 64'd1);
    checkOutput("rst_post_dat", 64'(o_wb_dat), 64'd10);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
